// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller with RISC-V debug transport registers.
// Exposes IDCODE, DTMCS and DMI data registers; BYPASS otherwise.
module jtag_tap #(
   parameter int DMI_ADDR_BITS = 7,
   parameter int DMI_DATA_BITS = 32,
   parameter int DMI_OP_BITS   = 2,
   parameter int IR_BITS       = 5,
   localparam int TAP_REQ_BITS =
      DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
   input  logic                    jtag_tck_i,
   input  logic                    jtag_rst_i,
   input  logic                    jtag_tms_i,
   input  logic                    jtag_tdi_i,
   output logic                    jtag_tdo_o,
   output logic                    tap_req_o,
   output logic [TAP_REQ_BITS-1:0] tap_data_o,
   output logic                    dmireset_o,
   input  logic [TAP_REQ_BITS-1:0] data_i,
   input  logic [31:0]             idcode_i,
   input  logic [31:0]             dtmcs_i
);

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } state_e;

   localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(5'h01);
   localparam logic [IR_BITS-1:0] IR_DTMCS  = IR_BITS'(5'h10);
   localparam logic [IR_BITS-1:0] IR_DMI    = IR_BITS'(5'h11);

   state_e                  state_q, state_d;
   logic [IR_BITS-1:0]      ir_q, ir_d;
   logic [IR_BITS-1:0]      ir_sr_q, ir_sr_d;
   logic [TAP_REQ_BITS-1:0] dr_sr_q, dr_sr_d;
   logic [TAP_REQ_BITS-1:0] tap_data_q, tap_data_d;

   logic sel_idcode, sel_dtmcs, sel_dmi, sel_byp;
   logic upd_dmi, upd_dtmcs;

   always_comb begin
      sel_idcode = (ir_q == IR_IDCODE);
      sel_dtmcs  = (ir_q == IR_DTMCS);
      sel_dmi    = (ir_q == IR_DMI);
      sel_byp    = !(sel_idcode || sel_dtmcs || sel_dmi);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = jtag_tms_i ? TLR    : RTI;
         RTI:    state_d = jtag_tms_i ? SEL_DR : RTI;
         SEL_DR: state_d = jtag_tms_i ? SEL_IR : CAP_DR;
         CAP_DR: state_d = jtag_tms_i ? EX1_DR : SH_DR;
         SH_DR:  state_d = jtag_tms_i ? EX1_DR : SH_DR;
         EX1_DR: state_d = jtag_tms_i ? UPD_DR : PAU_DR;
         PAU_DR: state_d = jtag_tms_i ? EX2_DR : PAU_DR;
         EX2_DR: state_d = jtag_tms_i ? UPD_DR : SH_DR;
         UPD_DR: state_d = jtag_tms_i ? SEL_DR : RTI;
         SEL_IR: state_d = jtag_tms_i ? TLR    : CAP_IR;
         CAP_IR: state_d = jtag_tms_i ? EX1_IR : SH_IR;
         SH_IR:  state_d = jtag_tms_i ? EX1_IR : SH_IR;
         EX1_IR: state_d = jtag_tms_i ? UPD_IR : PAU_IR;
         PAU_IR: state_d = jtag_tms_i ? EX2_IR : PAU_IR;
         EX2_IR: state_d = jtag_tms_i ? UPD_IR : SH_IR;
         UPD_IR: state_d = jtag_tms_i ? SEL_DR : RTI;
      endcase
   end

   always_comb begin
      ir_d    = ir_q;
      ir_sr_d = ir_sr_q;
      case (state_q)
         TLR:     ir_d    = IR_IDCODE;
         CAP_IR:  ir_sr_d = IR_BITS'(1);
         SH_IR:   ir_sr_d = {jtag_tdi_i, ir_sr_q[IR_BITS-1:1]};
         UPD_IR:  ir_d    = ir_sr_q;
         default: ;
      endcase
   end

   // TDI enters at the top of the selected register's length.
   always_comb begin
      dr_sr_d = dr_sr_q;
      case (state_q)
         CAP_DR: begin
            unique case (1'b1)
               sel_idcode: dr_sr_d = TAP_REQ_BITS'(idcode_i);
               sel_dtmcs:  dr_sr_d = TAP_REQ_BITS'(dtmcs_i);
               sel_dmi:    dr_sr_d = data_i;
               sel_byp:    dr_sr_d = '0;
            endcase
         end
         SH_DR: begin
            dr_sr_d = dr_sr_q >> 1;
            unique case (1'b1)
               sel_idcode: dr_sr_d[31] = jtag_tdi_i;
               sel_dtmcs:  dr_sr_d[31] = jtag_tdi_i;
               sel_dmi:    dr_sr_d[TAP_REQ_BITS-1] = jtag_tdi_i;
               sel_byp:    dr_sr_d[0] = jtag_tdi_i;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      upd_dmi    = (state_q == UPD_DR) && sel_dmi;
      upd_dtmcs  = (state_q == UPD_DR) && sel_dtmcs;
      tap_data_d = upd_dmi ? dr_sr_q : tap_data_q;
   end

   always_ff @(posedge jtag_tck_i) begin
      if (jtag_rst_i) begin
         state_q    <= TLR;
         ir_q       <= IR_IDCODE;
         ir_sr_q    <= '0;
         dr_sr_q    <= '0;
         tap_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ir_sr_q    <= ir_sr_d;
         dr_sr_q    <= dr_sr_d;
         tap_data_q <= tap_data_d;
      end
   end

   // Strobes are suppressed while reset is being applied.
   always_comb begin
      jtag_tdo_o = 1'b0;
      if (state_q == SH_IR) jtag_tdo_o = ir_sr_q[0];
      if (state_q == SH_DR) jtag_tdo_o = dr_sr_q[0];
      tap_req_o  = upd_dmi && !jtag_rst_i;
      dmireset_o = upd_dtmcs && dr_sr_q[16] && !jtag_rst_i;
      tap_data_o = upd_dmi ? dr_sr_q : tap_data_q;
   end

endmodule

// File: tb/tb_jtag_tap.sv
// Scoreboard bench for jtag_tap: stimulus queues expected TDO bits
// and strobes; a negedge monitor pops and compares them.
module tb_jtag_tap;

   logic        tck;
   logic        rst;
   logic        tms;
   logic        tdi;
   logic        tdo;
   logic        req;
   logic [40:0] tdata;
   logic        dmirst;
   logic [40:0] data;
   logic [31:0] idcode;
   logic [31:0] dtmcs;

   int n_pass = 0;
   int n_tot  = 0;

   logic        tdo_vld;
   logic        tdo_q[$];
   logic [40:0] req_q[$];
   logic [1:0]  rst_q[$];

   jtag_tap dut (
      .jtag_tck_i (tck),
      .jtag_rst_i (rst),
      .jtag_tms_i (tms),
      .jtag_tdi_i (tdi),
      .jtag_tdo_o (tdo),
      .tap_req_o  (req),
      .tap_data_o (tdata),
      .dmireset_o (dmirst),
      .data_i     (data),
      .idcode_i   (idcode),
      .dtmcs_i    (dtmcs)
   );

   initial begin
      tck = 1'b0;
      forever #5 tck = ~tck;
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   always @(negedge tck) begin
      if (tdo_vld && tdo_q.size() > 0)
         check("tdo", 64'(tdo), 64'(tdo_q.pop_front()));
      if (req === 1'b1) begin
         if (req_q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_req: got 1 want 0");
         end else begin
            check("tap_data", 64'(tdata), 64'(req_q.pop_front()));
         end
      end
      if (dmirst === 1'b1) begin
         if (rst_q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_dmireset: got 1 want 0");
         end else begin
            check("dmireset", 64'({dmirst, req}),
                  64'(rst_q.pop_front()));
         end
      end
   end

   // One TCK cycle: drive TMS/TDI and optionally expect a TDO bit
   // for the current state.
   task automatic cyc(input logic t, input logic d,
                      input logic c, input logic e);
      tms     = t;
      tdi     = d;
      tdo_vld = c;
      if (c) tdo_q.push_back(e);
      @(posedge tck);
      #1;
   endtask

   task automatic goto_sh_dr();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   task automatic finish_dr();
      cyc(1, 0, 1, 0);
      cyc(0, 0, 1, 0);
   endtask

   task automatic shift_dr(input int n, input logic [40:0] din,
                           input logic [40:0] dexp, input int pz);
      for (int i = 0; i < n; i++) begin
         cyc((i == n-1) || (i == pz-1), din[i], 1, dexp[i]);
         if (pz != 0 && i == pz-1 && i != n-1) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 1, 0);
            cyc(1, 0, 1, 0);
            cyc(0, 0, 1, 0);
         end
      end
   endtask

   task automatic load_ir(input logic [4:0] code);
      logic [4:0] cap;
      cap = 5'b00001;
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         cyc(i == 4, code[i], 1, cap[i]);
      cyc(1, 0, 1, 0);
      cyc(0, 0, 0, 0);
   endtask

   task automatic read_idcode();
      goto_sh_dr();
      shift_dr(32, 41'h0, {9'h0, idcode}, 0);
      finish_dr();
   endtask

   logic [40:0] v1, v2, c2;

   initial begin
      tdo_vld = 1'b0;
      rst     = 1'b1;
      tms     = 1'b1;
      tdi     = 1'b0;
      data    = '0;
      idcode  = 32'h1E200A6F;
      dtmcs   = 32'h00005071;
      @(posedge tck);
      #1;
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("rst_tdo", 64'(tdo), 64'h0);
      check("rst_req", 64'(req), 64'h0);
      check("rst_dmireset", 64'(dmirst), 64'h0);
      check("rst_tap_data", 64'(tdata), 64'h0);
      rst = 1'b0;
      cyc(0, 0, 1, 0);

      read_idcode();

      load_ir(5'h11);
      data = 41'h3;
      v1   = {7'h10, 32'h00000001, 2'b10};
      req_q.push_back(v1);
      goto_sh_dr();
      shift_dr(41, v1, 41'h3, 0);
      finish_dr();
      cyc(0, 0, 0, 0);
      check("tap_data_hold", 64'(tdata), 64'(v1));

      data = {7'h05, 32'hDEADBEEF, 2'b01};
      v2   = {7'h22, 32'hCAFEF00D, 2'b11};
      c2   = data;
      req_q.push_back(v2);
      goto_sh_dr();
      shift_dr(41, v2, c2, 20);
      finish_dr();

      load_ir(5'h10);
      check("tap_data_hold2", 64'(tdata), 64'(v2));
      rst_q.push_back(2'b10);
      goto_sh_dr();
      shift_dr(32, 41'h00010000, {9'h0, dtmcs}, 0);
      finish_dr();
      goto_sh_dr();
      shift_dr(32, 41'h0, {9'h0, dtmcs}, 0);
      finish_dr();
      goto_sh_dr();
      shift_dr(32, 41'h00020000, {9'h0, dtmcs}, 0);
      finish_dr();

      load_ir(5'h1F);
      goto_sh_dr();
      shift_dr(4, 41'b1101, 41'b1010, 0);
      finish_dr();
      load_ir(5'h05);
      goto_sh_dr();
      shift_dr(3, 41'b011, 41'b110, 0);
      finish_dr();

      goto_sh_dr();
      cyc(0, 1, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      idcode = 32'h12345678;
      read_idcode();

      load_ir(5'h11);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 1);
      cyc(0, 1, 1, 0);
      rst = 1'b1;
      cyc(0, 0, 0, 0);
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      idcode = 32'hA5C3_0F81;
      read_idcode();

      load_ir(5'h11);
      goto_sh_dr();
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
      rst = 1'b1;
      cyc(1, 0, 0, 0);
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      read_idcode();

      tdo_vld = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("req_q_empty", 64'(req_q.size()), 64'h0);
      check("rst_q_empty", 64'(rst_q.size()), 64'h0);
      check("tdo_q_empty", 64'(tdo_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
